// File: rtl/cfs_apb_ctrl_pkg.sv
// rtl/cfs_apb_ctrl_pkg.sv - shared types, default widths and field helper for the APB master arbiter
package cfs_apb_ctrl_pkg;

  // APB master phase sequencing
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 16;

  // Upper bounds the field helper is sized for
  localparam int MAX_NUM_REQ = 8;
  localparam int MAX_FIELD_W = 64;
  localparam int MAX_FLAT_W  = MAX_NUM_REQ * MAX_FIELD_W;

  // Pull field idx (each width bits wide) out of a flattened per-requester vector.
  // Callers zero-extend the vector to MAX_FLAT_W and truncate the result.
  function automatic logic [MAX_FIELD_W-1:0] get_field(
    input logic [MAX_FLAT_W-1:0] flat,
    input int                    idx,
    input int                    width
  );
    logic [MAX_FLAT_W-1:0]  shifted;
    logic [MAX_FIELD_W-1:0] mask;
    shifted = flat >> (idx * width);
    mask    = {MAX_FIELD_W{1'b1}} >> (MAX_FIELD_W - width);
    return shifted[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/cfs_apb_rr_arbiter.sv
// rtl/cfs_apb_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module cfs_apb_rr_arbiter
  import cfs_apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // Search upward from last_grant+1, wrapping, so the previous owner is checked last
  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cand_idx;
    logic       found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_grant) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (enable && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cfs_apb_master_arbiter.sv
// rtl/cfs_apb_master_arbiter.sv - round-robin sharing of one APB master port with timeout abort
module cfs_apb_master_arbiter
  import cfs_apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          rsp_timeout,
  output logic                          psel,
  output logic                          penable,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Abort fires on the access cycle that would make the wait count equal TIMEOUT
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] owner_q;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             psel_d, penable_d;
  logic             load;
  logic             complete;
  logic             abort;
  logic             arb_en;
  logic             timeout_hit;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  // A grant may only happen while idle or on a normally completing access cycle
  assign arb_en      = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);
  assign timeout_hit = (TIMEOUT > 0) && (state_q == ST_ACCESS) && !pready && (tcnt_q == CNT_LAST);
  assign req_ready   = grant;

  cfs_apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Next state, next APB control values and wait counter
  always_comb begin
    state_d   = state_q;
    psel_d    = 1'b0;
    penable_d = 1'b0;
    tcnt_d    = '0;
    load      = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_SETUP;
          psel_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          complete = 1'b1;
          if (|grant) begin
            // back-to-back: psel stays high, penable drops for the new setup
            state_d = ST_SETUP;
            psel_d  = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          tcnt_d    = (TIMEOUT > 0) ? tcnt_q + CNT_W'(1) : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered APB outputs, captured request fields and arbitration history
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel         <= 1'b0;
      penable      <= 1'b0;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      tcnt_q       <= '0;
    end else begin
      psel    <= psel_d;
      penable <= penable_d;
      tcnt_q  <= tcnt_d;
      if (load) begin
        paddr        <= ADDR_WIDTH'(get_field(MAX_FLAT_W'(req_addr), int'(grant_idx), ADDR_WIDTH));
        pwdata       <= DATA_WIDTH'(get_field(MAX_FLAT_W'(req_wdata), int'(grant_idx), DATA_WIDTH));
        pwrite       <= req_write[grant_idx];
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

  // Registered response: one-cycle valid pulse, status fields hold until the next completion
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (complete) begin
        rsp_valid   <= NUM_REQ'(1) << owner_q;
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_slverr  <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_valid   <= NUM_REQ'(1) << owner_q;
        rsp_rdata   <= '0;
        rsp_slverr  <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cfs_apb_master_arbiter.sv
// tb/tb_cfs_apb_master_arbiter.sv - randomized self-checking bench with transaction-level reference model
module tb_cfs_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_write = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  cfs_apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stimulus controls
  logic        auto_req = 1'b0;
  logic [N-1:0] rq_en = '0;
  int unsigned req_pct = 0;
  int unsigned drop_pct = 0;
  int unsigned slv_wmin = 0;
  int unsigned slv_wmax = 0;
  logic        slv_tie0 = 1'b0;
  int          slv_err_mode = 0;   // 0 random, 1 force error, 2 force ok
  logic        slv_fix_data = 1'b0;
  logic [DW-1:0] slv_data = '0;
  int unsigned slv_w = 0;
  int unsigned slv_c = 0;

  // Reference model: one transfer in flight, described by owner, fields and elapsed waits
  logic        m_active = 1'b0;
  logic        m_setup = 1'b0;
  int          m_waits = 0;
  int          m_last = N - 1;
  int          m_owner = 0;
  logic [AW-1:0] m_addr = '0;
  logic        m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [N-1:0] e_rsp_valid = '0;
  logic [DW-1:0] e_rdata = '0;
  logic        e_slverr = 1'b0;
  logic        e_timeout = 1'b0;
  logic [N-1:0] acc_mask = '0;
  logic [N-1:0] exp_ready;
  int          m_win;
  logic        m_done, m_abort, m_slot;
  int          obs_q[$];

  always @(negedge pclk) begin
    if (preset) begin
      m_active = 1'b0; m_setup = 1'b0; m_waits = 0; m_last = N - 1;
      e_rsp_valid = '0; e_rdata = '0; e_slverr = 1'b0; e_timeout = 1'b0;
      acc_mask = '0;
    end else begin
      check_eq("psel", 64'(psel), 64'(m_active));
      check_eq("penable", 64'(penable), 64'(m_active && !m_setup));
      if (m_active) begin
        check_eq("paddr", 64'(paddr), 64'(m_addr));
        check_eq("pwrite", 64'(pwrite), 64'(m_write));
        check_eq("pwdata", 64'(pwdata), 64'(m_wdata));
      end
      check_eq("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      check_eq("rsp_slverr", 64'(rsp_slverr), 64'(e_slverr));
      check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e_timeout));

      m_done  = m_active && !m_setup && pready;
      m_abort = m_active && !m_setup && !pready && (m_waits + 1 == TO);
      m_slot  = !m_active || m_done;
      m_win   = -1;
      if (m_slot) begin
        for (int k = 1; k <= N; k++) begin
          if (m_win < 0 && req_valid[(m_last + k) % N]) m_win = (m_last + k) % N;
        end
      end
      exp_ready = '0;
      if (m_win >= 0) exp_ready[m_win] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      for (int i = 0; i < N; i++) if (req_ready[i]) obs_q.push_back(i);

      e_rsp_valid = '0;
      if (m_done) begin
        e_rsp_valid[m_owner] = 1'b1;
        e_rdata   = m_write ? '0 : prdata;
        e_slverr  = pslverr;
        e_timeout = 1'b0;
      end else if (m_abort) begin
        e_rsp_valid[m_owner] = 1'b1;
        e_rdata   = '0;
        e_slverr  = 1'b1;
        e_timeout = 1'b1;
      end
      if (m_win >= 0) begin
        m_active = 1'b1; m_setup = 1'b1; m_waits = 0;
        m_owner = m_win; m_last = m_win;
        m_addr  = req_addr[m_win*AW +: AW];
        m_write = req_write[m_win];
        m_wdata = req_wdata[m_win*DW +: DW];
      end else if (m_done || m_abort) begin
        m_active = 1'b0;
      end else if (m_active && m_setup) begin
        m_setup = 1'b0;
      end else if (m_active) begin
        m_waits++;
      end
      acc_mask = exp_ready;
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Advance n cycles; inputs change 1 time unit after each rising edge
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge pclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (auto_req) begin
          if (req_valid[i] && ($urandom_range(99) < drop_pct)) begin
            req_valid[i] = 1'b0;
          end else if (!req_valid[i] && rq_en[i] && ($urandom_range(99) < req_pct)) begin
            req_valid[i] = 1'b1;
            set_req(i, AW'($urandom), 1'($urandom), $urandom);
          end
        end
      end
      if (slv_tie0) begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end else if (psel && !penable) begin
        slv_w = $urandom_range(slv_wmax, slv_wmin); slv_c = 0;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end else if (psel && penable) begin
        if (slv_c < slv_w) begin
          pready = 1'b0; slv_c++; prdata = $urandom; pslverr = 1'($urandom);
        end else begin
          pready  = 1'b1;
          prdata  = slv_fix_data ? slv_data : $urandom;
          pslverr = (slv_err_mode == 1) ? 1'b1 : (slv_err_mode == 2) ? 1'b0 : 1'($urandom);
        end
      end else begin
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    preset = 1'b1;
    req_valid = '0;
    step(3);
    preset = 1'b0;
  endtask

  task automatic check_order(input string tag, input int n, input int exp0, input int exp1,
                             input int exp2, input int exp3, input int exp4);
    int exp_a[5];
    int got;
    exp_a = '{exp0, exp1, exp2, exp3, exp4};
    for (int k = 0; k < n; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : -1;
      check_eq(tag, 64'(got), 64'(exp_a[k]));
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check_eq("rst_psel", 64'(psel), 64'(0));
    check_eq("rst_penable", 64'(penable), 64'(0));
    check_eq("rst_paddr", 64'(paddr), 64'(0));
    check_eq("rst_pwdata", 64'(pwdata), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("rst_rsp_flags", 64'({rsp_slverr, rsp_timeout}), 64'(0));
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    preset = 1'b0;

    // Single write from requester 2, no wait states
    slv_wmin = 0; slv_wmax = 0; slv_err_mode = 2;
    obs_q.delete();
    req_valid[2] = 1'b1;
    set_req(2, 16'h0010, 1'b1, 32'hDEADBEEF);
    step(6);
    check_order("a_grant", 1, 2, 0, 0, 0, 0);
    check_eq("a_slverr", 64'(rsp_slverr), 64'(0));
    check_eq("a_psel_idle", 64'(psel), 64'(0));

    // Read with 3 wait states and slave error
    slv_wmin = 3; slv_wmax = 3; slv_err_mode = 1; slv_fix_data = 1'b1; slv_data = 32'h12345678;
    req_valid[0] = 1'b1;
    set_req(0, 16'h0044, 1'b0, 32'h0);
    step(10);
    check_eq("b_rdata", 64'(rsp_rdata), 64'h12345678);
    check_eq("b_slverr", 64'(rsp_slverr), 64'(1));
    slv_fix_data = 1'b0; slv_err_mode = 0;

    // All requesters continuously valid: strict rotation from requester 0
    do_reset();
    obs_q.delete();
    auto_req = 1'b1; rq_en = 4'b1111; req_pct = 100; drop_pct = 0;
    slv_wmin = 0; slv_wmax = 2;
    step(40);
    check_order("c_order", 5, 0, 1, 2, 3, 0);

    // Timeout abort with pready tied low, then a normal transfer
    auto_req = 1'b0;
    do_reset();
    slv_tie0 = 1'b1;
    req_valid[1] = 1'b1;
    set_req(1, 16'h0200, 1'b0, 32'h0);
    step(25);
    check_eq("d_timeout", 64'(rsp_timeout), 64'(1));
    check_eq("d_slverr", 64'(rsp_slverr), 64'(1));
    check_eq("d_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("d_psel", 64'(psel), 64'(0));
    slv_tie0 = 1'b0; slv_wmin = 0; slv_wmax = 0; slv_err_mode = 2;
    req_valid[2] = 1'b1;
    set_req(2, 16'h0300, 1'b1, 32'hCAFE0001);
    step(6);
    check_eq("d_after_timeout", 64'(rsp_timeout), 64'(0));
    check_eq("d_after_slverr", 64'(rsp_slverr), 64'(0));
    slv_err_mode = 0;

    // Asynchronous reset during requester 1's access phase
    do_reset();
    slv_wmin = 5; slv_wmax = 5;
    req_valid[1] = 1'b1;
    set_req(1, 16'h0100, 1'b0, 32'h0);
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (psel && penable) break;
    end
    check_eq("e_in_access", 64'(psel && penable), 64'(1));
    preset = 1'b1;
    #1;
    check_eq("e_psel", 64'(psel), 64'(0));
    check_eq("e_penable", 64'(penable), 64'(0));
    check_eq("e_rsp_valid", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    step(2);
    obs_q.delete();
    auto_req = 1'b1; rq_en = 4'b1111; req_pct = 100; slv_wmin = 0; slv_wmax = 2;
    preset = 1'b0;
    step(8);
    check_order("e_first", 1, 0, 0, 0, 0, 0);

    // Requester 3 withdraws before its turn while 0 and 1 stay active
    auto_req = 1'b0;
    do_reset();
    obs_q.delete();
    auto_req = 1'b1; rq_en = 4'b0011; req_pct = 100; drop_pct = 0;
    slv_wmin = 0; slv_wmax = 1;
    req_valid = 4'b1011;
    set_req(0, 16'h1000, 1'b1, 32'h1); set_req(1, 16'h1001, 1'b0, 32'h0);
    set_req(3, 16'h1003, 1'b1, 32'h3);
    step(1);
    req_valid[3] = 1'b0;
    step(20);
    check_order("f_order", 3, 0, 1, 0, 0, 0);
    begin
      int seen3;
      seen3 = 0;
      foreach (obs_q[k]) if (obs_q[k] == 3) seen3++;
      check_eq("f_never3", 64'(seen3), 64'(0));
    end

    // Long randomized run, including waits past the timeout limit
    do_reset();
    auto_req = 1'b1; rq_en = 4'b1111; req_pct = 30; drop_pct = 5;
    slv_wmin = 0; slv_wmax = 20; slv_err_mode = 0;
    step(3000);
    auto_req = 1'b0; req_valid = '0;
    step(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
